code_entry: RTL and testbench

- Upstream input stage for the mastermind top level and its code maker/breaker units.
- Conditions one raw player enter button: 2-flop synchroniser, debounce, rising-edge detect.
- Assembles four 3-bit SW symbols, MSB-first, into one 12-bit code.
- Presents the code to the consumer through a valid/ready handshake.
- One instance per player; the top level drives enable for whichever player is active.

---
 rtl/code_entry.sv | 137 +++++++++++++
 tb/tb_code_entry.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry.sv
// code_entry: per-player enter-button conditioner and symbol assembler.
// Debounced presses capture SW into a 4-symbol code offered over valid/ready.
module code_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DIGIT_W         = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              clear,
    input  logic                              enter,
    input  logic [DIGIT_W-1:0]                SW,
    input  logic                              code_ready,
    output logic [DIGITS*DIGIT_W-1:0]         code,
    output logic                              code_valid,
    output logic [DIGITS*DIGIT_W-1:0]         partial,
    output logic [$clog2(DIGITS+1)-1:0]       digit_count,
    output logic                              enter_pulse
);

    localparam int unsigned CODE_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    logic            s1, s2, db;
    logic [DB_W-1:0] db_cnt;
    logic            db_last;
    logic            rise;

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   partial_nxt, code_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                valid_nxt;

    assign db_last = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    // Rise event: the edge at which the debounced level flips 0->1.
    assign rise    = s2 && !db && db_last;

    // Synchroniser, debouncer and registered rise strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db          <= 1'b0;
            db_cnt      <= '0;
            enter_pulse <= 1'b0;
        end else begin
            s1          <= enter;
            s2          <= s1;
            enter_pulse <= rise;
            if (s2 == db) begin
                db_cnt <= '0;
            end else if (db_last) begin
                db     <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            partial     <= '0;
            digit_count <= '0;
            code        <= '0;
            code_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            partial     <= partial_nxt;
            digit_count <= count_nxt;
            code        <= code_nxt;
            code_valid  <= valid_nxt;
        end
    end

    // Next state: clear/disable beats accept, accept beats capture.
    always_comb begin
        state_nxt   = state;
        partial_nxt = partial;
        count_nxt   = digit_count;
        code_nxt    = code;
        valid_nxt   = code_valid;
        if (clear || !enable) begin
            partial_nxt = '0;
            count_nxt   = '0;
            code_nxt    = '0;
            valid_nxt   = 1'b0;
            state_nxt   = (enable && clear) ? COLLECT : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    partial_nxt = '0;
                    count_nxt   = '0;
                    state_nxt   = COLLECT;
                end
                COLLECT: begin
                    if (rise) begin
                        // Slot 0 is the most significant symbol.
                        for (int i = 0; i < DIGITS; i++) begin
                            if (digit_count == CNT_W'(i)) begin
                                partial_nxt[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = SW;
                            end
                        end
                        count_nxt = digit_count + CNT_W'(1);
                        if (digit_count == CNT_W'(DIGITS - 1)) begin
                            code_nxt  = partial_nxt;
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (code_ready) begin
                        valid_nxt   = 1'b0;
                        partial_nxt = '0;
                        count_nxt   = '0;
                        state_nxt   = COLLECT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_entry.sv
// Bench for code_entry: hand-derived vector table, then random stimulus
// checked every cycle against a queue-based reference model.
module tb_code_entry;

    localparam int D      = 4;
    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, enable = 1'b0, clear = 1'b0, enter = 1'b0, code_ready = 1'b0;
    logic [2:0]  sw = 3'd0;
    logic [11:0] code, partial;
    logic        code_valid, enter_pulse;
    logic [2:0]  digit_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    code_entry #(.DEBOUNCE_CYCLES(D), .DIGITS(DIGITS), .DIGIT_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .enter(enter),
        .SW(sw), .code_ready(code_ready), .code(code), .code_valid(code_valid),
        .partial(partial), .digit_count(digit_count), .enter_pulse(enter_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: debounced level flips after D consecutive disagreeing
    // synchronised samples; the code is a queue of captured symbols.
    int          m_state;            // 0 idle, 1 collecting, 2 holding
    logic        m_s1, m_s2, m_db, m_pulse, m_valid;
    logic [11:0] m_code;
    logic [2:0]  m_syms[$];
    logic        m_win[$];

    function automatic logic [11:0] m_partial();
        logic [11:0] p;
        p = '0;
        foreach (m_syms[i]) p = p | (12'(m_syms[i]) << (3 * (3 - i)));
        return p;
    endfunction

    always @(posedge clk) begin : model
        logic rise;
        rise = 1'b0;
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_pulse = 0; m_valid = 0;
            m_code = '0; m_state = 0;
            m_syms.delete(); m_win.delete();
        end else begin
            if (m_s2 == m_db) begin
                m_win.delete();
            end else begin
                m_win.push_back(m_s2);
                if (m_win.size() == D) begin
                    rise = m_s2;
                    m_db = m_s2;
                    m_win.delete();
                end
            end
            m_pulse = rise;
            m_s2 = m_s1;
            m_s1 = enter;
            if (clear || !enable) begin
                m_syms.delete();
                m_valid = 0;
                m_code  = '0;
                m_state = (enable && clear) ? 1 : 0;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 2) begin
                if (code_ready) begin
                    m_syms.delete();
                    m_valid = 0;
                    m_state = 1;
                end
            end else if (rise) begin
                m_syms.push_back(sw);
                if (m_syms.size() == DIGITS) begin
                    m_code  = m_partial();
                    m_valid = 1;
                    m_state = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model digit_count", 12'(digit_count), 12'(m_syms.size()));
            chk("model partial", partial, m_partial());
            chk("model code_valid", 12'(code_valid), 12'(m_valid));
            chk("model code", code, m_code);
            chk("model enter_pulse", 12'(enter_pulse), 12'(m_pulse));
        end
    end

    typedef struct {
        int          n;
        logic        rst, en, clr, ent, rdy;
        logic [2:0]  sw;
        logic [2:0]  cnt;
        logic        val, pls;
        logic [11:0] part, cd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input int rst, input int en, input int clr,
                                input int ent, input int s, input int rdy, input int c,
                                input int val, input int p, input int cd, input int pl);
        vec_t v;
        v.n = n; v.rst = 1'(rst); v.en = 1'(en); v.clr = 1'(clr); v.ent = 1'(ent);
        v.sw = 3'(s); v.rdy = 1'(rdy); v.cnt = 3'(c); v.val = 1'(val);
        v.part = 12'(p); v.cd = 12'(cd); v.pls = 1'(pl);
        tbl.push_back(v);
    endfunction

    // Clean press (rise on 6th edge) then clean release.
    function automatic void press(input int s, input int c, input int p, input int val, input int cd);
        add(6, 1, 1, 0, 1, s, 0, c, val, p, cd, 1);
        add(6, 1, 1, 0, 0, s, 0, c, val, p, cd, 0);
    endfunction

    initial begin
        int lvl, hold_left;
        // reset and enable
        add(2, 0, 0, 0, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
        // single clean press: capture at E0+5, one pulse, no repeat while held
        add(5, 1, 1, 0, 1, 5, 0, 0, 0, 'h000, 'h000, 0);
        add(1, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 1);
        add(1, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(10, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(6, 1, 1, 0, 0, 5, 0, 1, 0, 'hA00, 'h000, 0);
        // bounce 1,0,1,1,0 then settle low
        add(1, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(1, 1, 1, 0, 0, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(1, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(1, 1, 1, 0, 1, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(1, 1, 1, 0, 0, 5, 0, 1, 0, 'hA00, 'h000, 0);
        add(8, 1, 1, 0, 0, 5, 0, 1, 0, 'hA00, 'h000, 0);
        // full code 1,2,3,4 = 0x29C, press in HOLD ignored, accept
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
        press(1, 1, 'h200, 0, 'h000);
        press(2, 2, 'h280, 0, 'h000);
        press(3, 3, 'h298, 0, 'h000);
        press(4, 4, 'h29C, 1, 'h29C);
        press(7, 4, 'h29C, 1, 'h29C);
        add(1, 1, 1, 0, 0, 0, 1, 0, 0, 'h000, 'h29C, 0);
        // clear on the same edge as the third rise event
        press(6, 1, 'hC00, 0, 'h29C);
        press(2, 2, 'hC80, 0, 'h29C);
        add(5, 1, 1, 0, 1, 5, 0, 2, 0, 'hC80, 'h29C, 0);
        add(1, 1, 1, 1, 1, 5, 0, 0, 0, 'h000, 'h000, 1);
        add(4, 1, 1, 0, 1, 5, 0, 0, 0, 'h000, 'h000, 0);
        add(6, 1, 1, 0, 0, 5, 0, 0, 0, 'h000, 'h000, 0);
        press(3, 1, 'h600, 0, 'h000);
        // enable drop in HOLD, re-enable with button still held
        press(0, 2, 'h600, 0, 'h000);
        press(7, 3, 'h638, 0, 'h000);
        press(2, 4, 'h63A, 1, 'h63A);
        add(8, 1, 1, 0, 1, 5, 0, 4, 1, 'h63A, 'h63A, 0);
        add(1, 1, 0, 0, 1, 5, 0, 0, 0, 'h000, 'h000, 0);
        add(5, 1, 1, 0, 1, 5, 0, 0, 0, 'h000, 'h000, 0);
        add(6, 1, 1, 0, 0, 5, 0, 0, 0, 'h000, 'h000, 0);
        press(5, 1, 'hA00, 0, 'h000);
        // reset mid-debounce, then a fresh full count with a single pulse
        add(4, 1, 1, 0, 1, 2, 0, 1, 0, 'hA00, 'h000, 0);
        add(1, 0, 1, 0, 1, 2, 0, 0, 0, 'h000, 'h000, 0);
        add(5, 1, 1, 0, 1, 2, 0, 0, 0, 'h000, 'h000, 0);
        add(1, 1, 1, 0, 1, 2, 0, 1, 0, 'h400, 'h000, 1);
        add(1, 1, 1, 0, 1, 2, 0, 1, 0, 'h400, 'h000, 0);
        add(6, 1, 1, 0, 0, 2, 0, 1, 0, 'h400, 'h000, 0);

        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; enable = tbl[i].en; clear = tbl[i].clr;
            enter = tbl[i].ent; sw = tbl[i].sw; code_ready = tbl[i].rdy;
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d digit_count", i), 12'(digit_count), 12'(tbl[i].cnt));
            chk($sformatf("row%0d partial", i), partial, tbl[i].part);
            chk($sformatf("row%0d code_valid", i), 12'(code_valid), 12'(tbl[i].val));
            chk($sformatf("row%0d code", i), code, tbl[i].cd);
            chk($sformatf("row%0d enter_pulse", i), 12'(enter_pulse), 12'(tbl[i].pls));
        end

        // random phase: button segments of 1..12 cycles mix bounces and presses
        lvl = 0;
        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_left == 0) begin
                lvl = int'($urandom_range(0, 1));
                hold_left = int'($urandom_range(1, 12));
            end
            hold_left--;
            enter      = 1'(lvl);
            sw         = 3'($urandom_range(0, 7));
            reset      = ($urandom_range(0, 499) != 0);
            enable     = ($urandom_range(0, 199) != 0);
            clear      = ($urandom_range(0, 299) == 0);
            code_ready = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
